// File: rtl/riscv_mem_pkg.sv
// Shared types and sizing helpers for the unified memory-port arbiter.
package riscv_mem_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_REQ_I,
    ARB_REQ_D,
    ARB_WAIT_I,
    ARB_WAIT_D
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  localparam int unsigned DEF_MAX_D_STREAK = 4;
  localparam int unsigned STREAK_W         = $clog2(DEF_MAX_D_STREAK + 1);

  function automatic int unsigned streakWidth(input int unsigned maxStreak);
    return $clog2(maxStreak + 1);
  endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module mem_arb_starve_ctr #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign sat = (count == MAX_V);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between instruction fetch and data
// accesses; data has priority, bounded by a starvation guard for fetch.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_valid,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_valid,
  output logic            stall_f,
  output logic            stall_m,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned SW = streakWidth(MAX_D_STREAK);

  arb_state_t      state, stateNext;
  logic            grant;
  owner_t          grantOwner;
  logic            rspI, rspD;
  logic            streakInc, streakClr, streakSat;
  logic [SW-1:0]   streak;

  mem_arb_starve_ctr #(
    .MAX (MAX_D_STREAK),
    .W   (SW)
  ) uStarveCtr (
    .clk   (clk),
    .reset (reset),
    .inc   (streakInc),
    .clr   (streakClr),
    .count (streak),
    .sat   (streakSat)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= stateNext;
  end

  // No arbitration while a completion pulse is out: the requester is
  // retiring that access and its req is not meaningful this cycle.
  always_comb begin
    stateNext  = state;
    grant      = 1'b0;
    grantOwner = OWNER_I;
    rspI       = 1'b0;
    rspD       = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (!(i_valid || d_valid) && (d_req || i_req)) begin
          grant = 1'b1;
          if (d_req && !(i_req && streakSat)) begin
            grantOwner = OWNER_D;
            stateNext  = ARB_REQ_D;
          end else begin
            grantOwner = OWNER_I;
            stateNext  = ARB_REQ_I;
          end
        end
      end
      ARB_REQ_I:  if (mem_gnt) stateNext = ARB_WAIT_I;
      ARB_REQ_D:  if (mem_gnt) stateNext = ARB_WAIT_D;
      ARB_WAIT_I: if (mem_rvalid) begin
        rspI      = 1'b1;
        stateNext = ARB_IDLE;
      end
      ARB_WAIT_D: if (mem_rvalid) begin
        rspD      = 1'b1;
        stateNext = ARB_IDLE;
      end
      default:    stateNext = ARB_IDLE;
    endcase
  end

  assign streakInc = grant && (grantOwner == OWNER_D) && i_req;
  assign streakClr = grant && !streakInc;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant) begin
      if (grantOwner == OWNER_D) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else begin
        mem_we    <= 1'b0;
        mem_addr  <= i_addr;
        mem_wdata <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_valid <= rspI;
      d_valid <= rspD;
      if (rspI) i_rdata <= mem_rdata;
      if (rspD) d_rdata <= mem_rdata;
    end
  end

  assign mem_req = (state == ARB_REQ_I) || (state == ARB_REQ_D);
  assign stall_f = i_req && !i_valid;
  assign stall_m = d_req && !d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester agents and a memory
// responder drive the DUT; monitors compare against an arbitration model.
module tb_mem_port_arbiter;

  localparam int XLEN = 32;
  localparam int MAXS = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            i_req, d_req, d_we;
  logic [XLEN-1:0] i_addr, d_addr, d_wdata;
  logic [XLEN-1:0] i_rdata, d_rdata;
  logic            i_valid, d_valid, stall_f, stall_m;
  logic            mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .stall_f(stall_f), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic we; logic [31:0] data; } dexp_t;
  logic [31:0] iq[$];
  dexp_t       dq[$];
  int          owners[$];

  bit respOn = 0, spur = 0;
  int gMin = 0, gMax = 0, rvMin = 0, rvMax = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chkBit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkInt(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'h10) return 32'h0050_0093;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Memory responder: grants after a chosen delay, answers after another.
  logic [31:0] pendAddr;
  logic        pendWe;
  int          gDly, rvDly;
  bit          awaitRv = 0, counting = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!respOn) begin
        awaitRv  = 0;
        counting = 0;
      end else begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (awaitRv) begin
          chkBit("mem_req_low_after_gnt", mem_req, 1'b0);
          if (rvDly == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pendWe ? $urandom : memData(pendAddr);
            awaitRv    = 0;
          end else rvDly--;
        end else if (mem_req) begin
          if (!counting) begin
            counting = 1;
            gDly     = $urandom_range(gMax, gMin);
          end
          if (gDly == 0) begin
            mem_gnt  = 1'b1;
            counting = 0;
            awaitRv  = 1;
            pendAddr = mem_addr;
            pendWe   = mem_we;
            rvDly    = $urandom_range(rvMax, rvMin);
          end else gDly--;
        end else if (spur && $urandom_range(7, 0) == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = 32'hDEAD;
        end
      end
    end
  end

  // Arbitration model and response scoreboard, sampled mid-cycle.
  logic        pI = 0, pD = 0, pWe = 0, prevMemReq = 0;
  logic [31:0] pIa, pDa, pWd;
  int          mStreak = 0;
  always @(negedge clk) begin
    if (reset) begin
      mStreak    = 0;
      prevMemReq = 0;
    end else begin
      if (mem_req && !prevMemReq) begin
        if (pD && !(pI && mStreak == MAXS)) begin
          owners.push_back(1);
          chkBit("grant_d_we", mem_we, pWe);
          chk("grant_d_addr", mem_addr, pDa);
          chk("grant_d_wdata", mem_wdata, pWd);
          mStreak = pI ? ((mStreak < MAXS) ? mStreak + 1 : MAXS) : 0;
        end else begin
          owners.push_back(0);
          chkBit("grant_i_requested", pI, 1'b1);
          chkBit("grant_i_we", mem_we, 1'b0);
          chk("grant_i_addr", mem_addr, pIa);
          mStreak = 0;
        end
      end
      prevMemReq = mem_req;
      chkBit("stall_f", stall_f, i_req & ~i_valid);
      chkBit("stall_m", stall_m, d_req & ~d_valid);
      if (i_valid) begin
        if (iq.size() == 0) chkBit("i_valid_unexpected", i_valid, 1'b0);
        else chk("i_rdata", i_rdata, iq.pop_front());
      end
      if (d_valid) begin
        if (dq.size() == 0) chkBit("d_valid_unexpected", d_valid, 1'b0);
        else begin
          dexp_t e;
          e = dq.pop_front();
          if (!e.we) chk("d_rdata", d_rdata, e.data);
        end
      end
    end
    pI = i_req; pD = d_req; pWe = d_we;
    pIa = i_addr; pDa = d_addr; pWd = d_wdata;
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic fetchTxn(input logic [31:0] a, output int lat);
    i_addr = a;
    i_req  = 1'b1;
    iq.push_back(memData(a));
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!i_valid && lat < 200);
    chkBit("fetch_completed", i_valid, 1'b1);
    i_req = 1'b0;
  endtask

  task automatic dataTxn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         output int lat);
    dexp_t e;
    d_we = we; d_addr = a; d_wdata = wd;
    d_req = 1'b1;
    e.we = we;
    e.data = memData(a);
    dq.push_back(e);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!d_valid && lat < 200);
    chkBit("data_completed", d_valid, 1'b1);
    d_req = 1'b0;
  endtask

  task automatic doReset(input int n);
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l1, l2, base;
    int expOrder[6] = '{1, 1, 1, 1, 0, 1};
    i_req = 0; d_req = 0; d_we = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chkBit("rst_mem_req", mem_req, 1'b0);
    chkBit("rst_mem_we", mem_we, 1'b0);
    chkBit("rst_i_valid", i_valid, 1'b0);
    chkBit("rst_d_valid", d_valid, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);

    // Fetch alone against a zero-wait memory.
    respOn = 1;
    fetchTxn(32'h10, l1);
    chkInt("fetch_latency_zero_wait", l1, 3);
    idle(2);

    // Simultaneous store and fetch: data first.
    base = owners.size();
    fork
      fetchTxn(32'h20, l1);
      dataTxn(1'b1, 32'h64, 32'hAB, l2);
    join
    chkInt("both_first_owner_data", owners[base], 1);
    chkBit("both_fetch_after_data", l1 > l2, 1'b1);
    idle(2);

    // Starvation guard with back-to-back loads.
    doReset(2);
    base = owners.size();
    fork
      fetchTxn(32'h30, l1);
      for (int k = 0; k < 5; k++) begin
        dataTxn(1'b0, 32'h100 + 32'(k * 4), 32'h0, l2);
        idle(1);
      end
    join
    chkInt("starve_grant_count", owners.size() - base, 6);
    for (int k = 0; k < 6; k++)
      if (base + k < owners.size()) chkInt("starve_grant_order", owners[base + k], expOrder[k]);
    idle(2);

    // Slow memory: grant after 3 extra cycles, rvalid 2 cycles after grant.
    gMin = 3; gMax = 3; rvMin = 1; rvMax = 1;
    dataTxn(1'b0, 32'h200, 32'h0, l2);
    chkInt("slow_load_latency", l2, 7);
    idle(3);
    gMin = 0; gMax = 0; rvMin = 0; rvMax = 0;

    // Spurious rvalid while idle leaves captured data alone.
    fetchTxn(32'h44, l1);
    idle(1);
    dataTxn(1'b0, 32'h48, 32'h0, l2);
    respOn = 0;
    idle(1);
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hDEAD;
    idle(2);
    mem_rvalid = 1'b0;
    @(negedge clk);
    chkBit("spur_i_valid", i_valid, 1'b0);
    chkBit("spur_d_valid", d_valid, 1'b0);
    chk("spur_i_rdata_kept", i_rdata, memData(32'h44));
    chk("spur_d_rdata_kept", d_rdata, memData(32'h48));
    @(posedge clk); #1;

    // Reset while waiting on a load, with the response arriving afterwards.
    d_we = 1'b0; d_addr = 32'h80; d_wdata = '0; d_req = 1'b1;
    idle(1);
    mem_gnt = 1'b1;
    idle(1);
    mem_gnt = 1'b0;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    d_req = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hBEEF;
    @(negedge clk);
    chkBit("rst_mid_mem_req", mem_req, 1'b0);
    chkBit("rst_mid_d_valid", d_valid, 1'b0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chkBit("late_rvalid_no_pulse", d_valid, 1'b0);
    chk("late_rvalid_d_rdata", d_rdata, 32'h0);
    chkBit("late_rvalid_mem_req", mem_req, 1'b0);
    @(posedge clk); #1;

    // Randomised traffic with variable memory latency and stray responses.
    gMin = 0; gMax = 2; rvMin = 0; rvMax = 2;
    spur = 1;
    respOn = 1;
    idle(1);
    fork
      for (int k = 0; k < 40; k++) begin
        idle(1 + $urandom_range(3, 0));
        fetchTxn($urandom & 32'hFFFF_FFFC, l1);
      end
      for (int k = 0; k < 40; k++) begin
        idle(1 + $urandom_range(2, 0));
        dataTxn(1'($urandom_range(1, 0)), $urandom, $urandom, l2);
      end
    join
    spur = 0;
    idle(6);
    chkInt("fetch_queue_drained", iq.size(), 0);
    chkInt("data_queue_drained", dq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
